// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, single-outstanding memory requests
// and a 2-entry instruction buffer presented to decode over valid/ready.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
    parameter int unsigned           PC_INCREMENT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INCREMENT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_req_q, mem_req_d;

    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [31:0]           buf_instr_q [2];
    logic [31:0]           buf_instr_d [2];
    logic [ADDR_WIDTH-1:0] buf_pc_q    [2];
    logic [ADDR_WIDTH-1:0] buf_pc_d    [2];

    logic                  pop;
    logic                  push;
    logic [ADDR_WIDTH-1:0] pc_seq;
    logic [1:0]            count_popped;
    logic [1:0]            count_pushed;
    logic                  room_no_push;
    logic                  room_push;

    assign instr_valid = (count_q != 2'd0);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instruction = instr_valid ? buf_instr_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? buf_pc_q[rd_ptr_q]    : '0;

    // Room is judged on occupancy after this cycle's pop (and push), so a
    // new request never lands in a full buffer.
    always_comb begin
        pop          = instr_valid & instr_ready;
        pc_seq       = pc_q + PC_STEP;
        count_popped = count_q - {1'b0, pop};
        count_pushed = count_popped + 2'd1;
        room_no_push = (count_popped < 2'd2);
        room_push    = (count_pushed < 2'd2);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    state_d    = S_WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect_pc;
                end else if (room_no_push) begin
                    state_d    = S_WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (mem_ack) begin
                        state_d    = S_WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = redirect_pc;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (mem_ack) begin
                    push = 1'b1;
                    pc_d = pc_seq;
                    if (room_push) begin
                        state_d    = S_WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_seq;
                    end else begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end

            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                // The stale response is dropped; the restart goes to the
                // newest target, which pc_q already holds unless redirected now.
                if (mem_ack) begin
                    if (redirect_valid || room_no_push) begin
                        state_d    = S_WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = redirect_valid ? redirect_pc : pc_q;
                    end else begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        if (redirect_valid) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                buf_instr_d[wr_ptr_q] = mem_rdata;
                buf_pc_d[wr_ptr_q]    = mem_addr_q;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            buf_instr_q <= '{default: '0};
            buf_pc_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    fetch_unit #(
        .ADDR_WIDTH  (32),
        .RESET_PC    (32'h0000_0000),
        .PC_INCREMENT(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .instr_pc      (instr_pc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_req;
    bit          m_discard;

    int unsigned n_vec;
    int unsigned n_err;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a queue of fetched words, a pc, and whether a request is out
    // and whether its data is to be thrown away.
    task automatic model_step();
        if (reset) begin
            m_q.delete();
            m_pc      = 32'h0;
            m_req     = 1'b0;
            m_addr    = 32'h0;
            m_discard = 1'b0;
        end else begin
            bit pop;
            pop = (m_q.size() != 0) && instr_ready;
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_pc;
                if (!m_req || mem_ack) begin
                    m_req     = 1'b1;
                    m_addr    = redirect_pc;
                    m_discard = 1'b0;
                end else begin
                    m_discard = 1'b1;
                end
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_req && mem_ack) begin
                    if (!m_discard) begin
                        m_q.push_back('{mem_rdata, m_addr});
                        m_pc = m_pc + 32'd4;
                    end
                    m_discard = 1'b0;
                    m_req     = 1'b0;
                end
                if (!m_req && m_q.size() < 2) begin
                    m_req  = 1'b1;
                    m_addr = m_pc;
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("mem_req", mem_req, m_req);
        chk("mem_addr", mem_addr, m_addr);
        chk("instr_valid", instr_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("instruction", instruction, m_q[0].instr);
            chk("instr_pc", instr_pc, m_q[0].pc);
        end
    endtask

    task automatic drive(input bit rst, input bit ack, input logic [31:0] rdata,
                         input bit redir, input logic [31:0] rpc, input bit rdy);
        reset          = rst;
        mem_ack        = ack;
        mem_rdata      = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        model_step();
    endtask

    task automatic settle();
        @(negedge clock);
        compare_model();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset state and streaming with ack held high
        drive(1, 0, 0, 0, 0, 0); settle();
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_ipc", instr_pc, 0);
        drive(0, 1, 32'h0 ^ K, 0, 0, 1); settle();
        chk("t1_first_req", mem_req, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", mem_addr, 32'(4 * i));
            if (i > 0) begin
                chk("t1_ipc", instr_pc, 32'(4 * (i - 1)));
                chk("t1_instr", instruction, 32'(4 * (i - 1)) ^ K);
            end
            drive(0, 1, m_addr ^ K, 0, 0, 1); settle();
        end

        // Backpressure
        drive(1, 0, 0, 0, 0, 0); settle();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, m_addr ^ K, 0, 0, 0); settle();
        end
        chk("t2_valid", instr_valid, 1);
        chk("t2_ipc", instr_pc, 32'h0);
        chk("t2_req_off", mem_req, 0);
        chk("t2_addr_frozen", mem_addr, 32'h4);
        drive(0, 1, m_addr ^ K, 0, 0, 1); settle();
        chk("t2_req_on", mem_req, 1);
        chk("t2_addr8", mem_addr, 32'h8);
        chk("t2_ipc4", instr_pc, 32'h4);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, m_addr ^ K, 0, 0, 0); settle();
            chk("t2_one_req", mem_req, 0);
            chk("t2_addr_hold", mem_addr, 32'h8);
        end

        // Redirect while a request is outstanding
        drive(1, 0, 0, 0, 0, 0); settle();
        drive(0, 0, 0, 0, 0, 1); settle();
        drive(0, 1, m_addr ^ K, 0, 0, 1); settle();
        drive(0, 1, m_addr ^ K, 0, 0, 1); settle();
        chk("t3_addr8", mem_addr, 32'h8);
        drive(0, 0, 0, 1, 32'h100, 1); settle();
        chk("t3_flush", instr_valid, 0);
        chk("t3_hold", mem_addr, 32'h8);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1); settle();
            chk("t3_hold", mem_addr, 32'h8);
            chk("t3_req", mem_req, 1);
        end
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 1); settle();
        chk("t3_restart", mem_addr, 32'h100);
        chk("t3_dropped", instr_valid, 0);
        drive(0, 1, 32'h100 ^ K, 0, 0, 0); settle();
        chk("t3_valid", instr_valid, 1);
        chk("t3_ipc", instr_pc, 32'h100);
        chk("t3_instr", instruction, 32'h100 ^ K);

        // Redirect in the same cycle as an ack
        drive(1, 0, 0, 0, 0, 0); settle();
        drive(0, 0, 0, 1, 32'h10, 1); settle();
        chk("t4_addr10", mem_addr, 32'h10);
        drive(0, 1, 32'h1234_5678, 1, 32'h40, 1); settle();
        chk("t4_empty", instr_valid, 0);
        chk("t4_addr40", mem_addr, 32'h40);
        chk("t4_req", mem_req, 1);
        drive(0, 1, 32'h40 ^ K, 0, 0, 0); settle();
        chk("t4_ipc", instr_pc, 32'h40);

        // PC wrap
        drive(1, 0, 0, 0, 0, 0); settle();
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 1); settle();
        chk("t5_addr_top", mem_addr, 32'hFFFF_FFFC);
        drive(0, 1, m_addr ^ K, 0, 0, 1); settle();
        chk("t5_ipc_top", instr_pc, 32'hFFFF_FFFC);
        chk("t5_addr_wrap", mem_addr, 32'h0);
        drive(0, 1, m_addr ^ K, 0, 0, 1); settle();
        chk("t5_ipc_wrap", instr_pc, 32'h0);

        // Reset mid-operation with an ack in the reset cycle
        drive(1, 0, 0, 0, 0, 0); settle();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, m_addr ^ K, 0, 0, 0); settle();
        end
        drive(0, 1, m_addr ^ K, 0, 0, 1); settle();
        chk("t6_busy_req", mem_req, 1);
        chk("t6_busy_valid", instr_valid, 1);
        drive(1, 1, m_addr ^ K, 0, 0, 1); settle();
        chk("t6_valid", instr_valid, 0);
        chk("t6_req", mem_req, 0);
        chk("t6_instr", instruction, 0);
        chk("t6_ipc", instr_pc, 0);
        drive(0, 0, 0, 0, 0, 0); settle();
        chk("t6_req_again", mem_req, 1);
        chk("t6_reset_pc", mem_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          r_rst;
            bit          r_ack;
            bit          r_red;
            bit          r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) == 0);
            r_ack = m_req && ($urandom_range(0, 2) != 0);
            r_red = ($urandom_range(0, 15) == 0);
            r_rdy = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
                r_pc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            else
                r_pc = $urandom() & 32'hFFFF_FFFC;
            drive(r_rst, r_ack, $urandom(), r_red, r_pc, r_rdy);
            settle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
